// File: rtl/whack_round_ctrl_pkg.sv
// Shared types and limits for the whack-a-mole round sequencer.
// The optional pause feature is enabled with the WHACK_PAUSE_EN macro.
package whack_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int COUNTDOWN_MAX = 9;
    localparam int ROUND_MAX     = 59;
    localparam int HOLD_MAX      = 15;

    // Out-of-range parameters are pulled back into 1..hi so the counters never wrap.
    function automatic int clamp_param(input int value, input int hi);
        if (value < 1)
            return 1;
        else if (value > hi)
            return hi;
        else
            return value;
    endfunction

endpackage

// File: rtl/whack_round_ctrl_if.sv
// Control/status bundle between the round sequencer and the button, divider and timer logic.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface whack_round_ctrl_if;

    logic       tick_1hz;
    logic       start_btn;
    logic       pause_btn;
    logic       timer_done;
    logic       timer_clear;
    logic       timer_run;
    logic       game_active;
    logic       round_over;
    logic [3:0] countdown;
    logic [5:0] elapsed;
    logic [2:0] state;

    modport master (
        input  tick_1hz, start_btn, pause_btn, timer_done,
        output timer_clear, timer_run, game_active, round_over, countdown, elapsed, state
    );

    modport slave (
        output tick_1hz, start_btn, pause_btn, timer_done,
        input  timer_clear, timer_run, game_active, round_over, countdown, elapsed, state
    );

endinterface

// File: rtl/whack_round_ctrl_rise_detect.sv
// Registered rising-edge detector: rise is high for the cycle where level is 1 but was 0 at the
// previous edge, so a held button produces exactly one rise.
module rise_detect (
    input  logic ClockIn,
    input  logic Reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge ClockIn) begin
        if (Reset)
            level_q <= 1'b0;
        else
            level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/whack_round_ctrl.sv
// Round sequencer: IDLE -> ARM countdown -> PLAY -> DONE hold -> IDLE, all outputs registered.
// Defining WHACK_PAUSE_EN makes pause_btn live and adds the PAUSED state.
module whack_round_ctrl
    import whack_pkg::*;
#(
    parameter int COUNTDOWN_S = 3,
    parameter int ROUND_S     = 20,
    parameter int HOLD_S      = 5
) (
    input logic               ClockIn,
    input logic               Reset,
    whack_round_ctrl_if.master bus
);

    localparam int         CD_VAL      = clamp_param(COUNTDOWN_S, COUNTDOWN_MAX);
    localparam int         ROUND_VAL   = clamp_param(ROUND_S, ROUND_MAX);
    localparam int         HOLD_VAL    = clamp_param(HOLD_S, HOLD_MAX);
    localparam logic [3:0] CD_LOAD     = 4'(CD_VAL);
    localparam logic [5:0] ROUND_LIMIT = 6'(ROUND_VAL);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_VAL - 1);

    state_t     state_q;
    logic       timer_clear_q;
    logic       timer_run_q;
    logic       game_active_q;
    logic       round_over_q;
    logic [3:0] countdown_q;
    logic [5:0] elapsed_q;
    logic [3:0] hold_q;
    logic       start_rise;
    logic       pause_rise;
    logic [5:0] elapsed_inc;
    logic       play_end;

    rise_detect start_edge (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .level   (bus.start_btn),
        .rise    (start_rise)
    );

    rise_detect pause_edge (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .level   (bus.pause_btn),
        .rise    (pause_rise)
    );

`ifndef WHACK_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause_rise;
`endif

    // A tick and timer_done on the same edge still credit the final second.
    assign elapsed_inc = (elapsed_q >= ROUND_LIMIT) ? ROUND_LIMIT : elapsed_q + 6'd1;
    assign play_end    = bus.timer_done | (bus.tick_1hz & (elapsed_inc == ROUND_LIMIT));

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q       <= IDLE;
            timer_clear_q <= 1'b1;
            timer_run_q   <= 1'b0;
            game_active_q <= 1'b0;
            round_over_q  <= 1'b0;
            countdown_q   <= 4'd0;
            elapsed_q     <= 6'd0;
            hold_q        <= 4'd0;
        end else begin
            round_over_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        state_q     <= ARM;
                        countdown_q <= CD_LOAD;
                        elapsed_q   <= 6'd0;
                    end
                end
                ARM: begin
                    if (bus.tick_1hz) begin
                        if (countdown_q <= 4'd1) begin
                            state_q       <= PLAY;
                            countdown_q   <= 4'd0;
                            elapsed_q     <= 6'd0;
                            timer_clear_q <= 1'b0;
                            timer_run_q   <= 1'b1;
                            game_active_q <= 1'b1;
                        end else begin
                            countdown_q <= countdown_q - 4'd1;
                        end
                    end
                end
                PLAY: begin
                    if (bus.tick_1hz)
                        elapsed_q <= elapsed_inc;
                    if (play_end) begin
                        state_q       <= DONE;
                        round_over_q  <= 1'b1;
                        timer_run_q   <= 1'b0;
                        game_active_q <= 1'b0;
                        hold_q        <= 4'd0;
                    end
`ifdef WHACK_PAUSE_EN
                    else if (pause_rise) begin
                        state_q       <= PAUSED;
                        timer_run_q   <= 1'b0;
                        game_active_q <= 1'b0;
                    end
`endif
                end
`ifdef WHACK_PAUSE_EN
                PAUSED: begin
                    if (bus.timer_done) begin
                        state_q      <= DONE;
                        round_over_q <= 1'b1;
                        hold_q       <= 4'd0;
                    end else if (pause_rise) begin
                        state_q       <= PLAY;
                        timer_run_q   <= 1'b1;
                        game_active_q <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (start_rise) begin
                        state_q       <= ARM;
                        countdown_q   <= CD_LOAD;
                        elapsed_q     <= 6'd0;
                        hold_q        <= 4'd0;
                        timer_clear_q <= 1'b1;
                    end else if (bus.tick_1hz) begin
                        if (hold_q == HOLD_LAST) begin
                            state_q       <= IDLE;
                            hold_q        <= 4'd0;
                            timer_clear_q <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    timer_clear_q <= 1'b1;
                    timer_run_q   <= 1'b0;
                    game_active_q <= 1'b0;
                    countdown_q   <= 4'd0;
                    elapsed_q     <= 6'd0;
                    hold_q        <= 4'd0;
                end
            endcase
        end
    end

    assign bus.timer_clear = timer_clear_q;
    assign bus.timer_run   = timer_run_q;
    assign bus.game_active = game_active_q;
    assign bus.round_over  = round_over_q;
    assign bus.countdown   = countdown_q;
    assign bus.elapsed     = elapsed_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Self-checking bench for whack_round_ctrl: directed round scenarios followed by random stimulus,
// every cycle compared against a phase-level reference model of the round rules.
module tb_whack_round_ctrl;

    localparam int COUNTDOWN_S = 3;
    localparam int ROUND_S     = 20;
    localparam int HOLD_S      = 5;

    localparam int P_IDLE   = 0;
    localparam int P_ARM    = 1;
    localparam int P_PLAY   = 2;
    localparam int P_PAUSED = 3;
    localparam int P_DONE   = 4;

`ifdef WHACK_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic ClockIn = 1'b0;
    logic Reset   = 1'b0;

    whack_round_ctrl_if bus ();

    whack_round_ctrl #(
        .COUNTDOWN_S (COUNTDOWN_S),
        .ROUND_S     (ROUND_S),
        .HOLD_S      (HOLD_S)
    ) dut (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .bus     (bus)
    );

    always #5 ClockIn = ~ClockIn;

    int checks = 0;
    int errors = 0;

    int phase;
    int cd;
    int el;
    int hold;
    bit prev_start;
    bit prev_pause;
    bit round_over;

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference: one call per clock edge, applying the round rules to the sampled inputs.
    task automatic model_step(input bit rst, input bit tick, input bit start, input bit pause, input bit done);
        bit srise;
        bit prise;
        if (rst) begin
            phase = P_IDLE; cd = 0; el = 0; hold = 0;
            prev_start = 0; prev_pause = 0; round_over = 0;
            return;
        end
        srise = start && !prev_start;
        prise = pause && !prev_pause;
        prev_start = start;
        prev_pause = pause;
        round_over = 0;
        case (phase)
            P_IDLE: if (srise) begin phase = P_ARM; cd = COUNTDOWN_S; el = 0; end
            P_ARM: if (tick) begin
                cd = cd - 1;
                if (cd == 0) begin phase = P_PLAY; el = 0; end
            end
            P_PLAY: begin
                if (tick && el < ROUND_S) el = el + 1;
                if (done || (tick && el == ROUND_S)) begin
                    phase = P_DONE; round_over = 1; hold = 0;
                end else if (PAUSE_EN && prise) begin
                    phase = P_PAUSED;
                end
            end
            P_PAUSED: begin
                if (done) begin phase = P_DONE; round_over = 1; hold = 0; end
                else if (prise) phase = P_PLAY;
            end
            P_DONE: begin
                if (srise) begin phase = P_ARM; cd = COUNTDOWN_S; el = 0; hold = 0; end
                else if (tick) begin
                    hold = hold + 1;
                    if (hold == HOLD_S) begin phase = P_IDLE; hold = 0; end
                end
            end
            default: phase = P_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check_output("state", 8'(bus.state), 8'(phase));
        check_output("timer_clear", 8'(bus.timer_clear), 8'(phase == P_IDLE || phase == P_ARM));
        check_output("timer_run", 8'(bus.timer_run), 8'(phase == P_PLAY));
        check_output("game_active", 8'(bus.game_active), 8'(phase == P_PLAY));
        check_output("round_over", 8'(bus.round_over), 8'(round_over));
        check_output("countdown", 8'(bus.countdown), 8'((phase == P_ARM) ? cd : 0));
        check_output("elapsed", 8'(bus.elapsed), 8'(el));
    endtask

    task automatic apply_stimulus(input bit rst, input bit tick, input bit start, input bit pause, input bit done);
        Reset          = rst;
        bus.tick_1hz   = tick;
        bus.start_btn  = start;
        bus.pause_btn  = pause;
        bus.timer_done = done;
        @(posedge ClockIn);
        model_step(rst, tick, start, pause, done);
        #1;
        compare_all();
    endtask

    task automatic tick_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(0, 1, 0, 0, 0);
            apply_stimulus(0, 0, 0, 0, 0);
        end
    endtask

    task automatic press_start();
        apply_stimulus(0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
    endtask

    task automatic press_pause();
        apply_stimulus(0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0);
    endtask

    initial begin
        bit start_lvl;
        bit pause_lvl;
        bit done_lvl;
        int guard;

        bus.tick_1hz = 0; bus.start_btn = 0; bus.pause_btn = 0; bus.timer_done = 0;
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);

        // Held start: a single ARM entry, then countdown into PLAY and a full-length round.
        for (int i = 0; i < 100; i++) apply_stimulus(0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        tick_cycles(COUNTDOWN_S);
        tick_cycles(ROUND_S);
        tick_cycles(HOLD_S);

        // Early timer_done, then start and tick together in DONE.
        press_start();
        tick_cycles(COUNTDOWN_S);
        tick_cycles(7);
        apply_stimulus(0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 1, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);

        // Pause mid-round, then reset near elapsed=10.
        tick_cycles(COUNTDOWN_S);
        tick_cycles(4);
        press_pause();
        tick_cycles(3);
        press_pause();
        guard = 0;
        while (el < 10 && phase == P_PLAY && guard < 40) begin
            tick_cycles(1);
            guard++;
        end
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);

        start_lvl = 0; pause_lvl = 0; done_lvl = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(15) == 0) start_lvl = !start_lvl;
            if ($urandom_range(23) == 0) pause_lvl = !pause_lvl;
            if (done_lvl) begin
                if ($urandom_range(3) == 0) done_lvl = 0;
            end else if ($urandom_range(99) == 0) begin
                done_lvl = 1;
            end
            apply_stimulus($urandom_range(799) == 0, $urandom_range(2) == 0, start_lvl, pause_lvl, done_lvl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
